// File: rtl/intersection_phase_controller_if.sv
// Bundles the tick/button inputs and the light/timer outputs of the
// intersection phase controller. The controller uses the master modport.
interface intersection_phase_controller_if;
  logic       tick;
  logic       ped_req_ns;
  logic       ped_req_ew;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [6:0] master_timer;
  logic       ped_enable_ns;
  logic       ped_enable_ew;
  logic [2:0] phase;

  modport master (
    input  tick,
    input  ped_req_ns,
    input  ped_req_ew,
    output ns_light,
    output ew_light,
    output master_timer,
    output ped_enable_ns,
    output ped_enable_ew,
    output phase
  );

  modport slave (
    output tick,
    output ped_req_ns,
    output ped_req_ew,
    input  ns_light,
    input  ew_light,
    input  master_timer,
    input  ped_enable_ns,
    input  ped_enable_ew,
    input  phase
  );
endinterface

// File: rtl/intersection_phase_controller.sv
// Two-road intersection sequencer: vehicle lights, phase countdown and
// pedestrian walk enables. Advances only on the 1 Hz tick strobe.
//
// state     | code | meaning
// RED_A     | 0    | all-red clearance before N-S green
// NS_GREEN  | 1    | N-S green, walk on N-S if a request was consumed at entry
// NS_YELLOW | 2    | N-S yellow
// RED_B     | 3    | all-red clearance before E-W green
// EW_GREEN  | 4    | E-W green, walk on E-W if a request was consumed at entry
// EW_YELLOW | 5    | E-W yellow
// 6, 7      | -    | illegal, recover to RED_A on the next edge
module intersection_phase_controller #(
  parameter int unsigned GREEN_TIME     = 30,
  parameter int unsigned PED_GREEN_TIME = 40,
  parameter int unsigned YELLOW_TIME    = 4,
  parameter int unsigned ALL_RED_TIME   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  intersection_phase_controller_if.master bus
);

  localparam logic [2:0] RED_A     = 3'd0;
  localparam logic [2:0] NS_GREEN  = 3'd1;
  localparam logic [2:0] NS_YELLOW = 3'd2;
  localparam logic [2:0] RED_B     = 3'd3;
  localparam logic [2:0] EW_GREEN  = 3'd4;
  localparam logic [2:0] EW_YELLOW = 3'd5;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  localparam logic [6:0] T_GREEN     = 7'(GREEN_TIME);
  localparam logic [6:0] T_PED_GREEN = 7'(PED_GREEN_TIME);
  localparam logic [6:0] T_YELLOW    = 7'(YELLOW_TIME);
  localparam logic [6:0] T_ALL_RED   = 7'(ALL_RED_TIME);

  logic [2:0] phase_q, phase_d;
  logic [6:0] timer_q, timer_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;
  logic       en_ns_q, en_ns_d;
  logic       en_ew_q, en_ew_d;
  logic       req_ns_q, req_ns_d;
  logic       req_ew_q, req_ew_d;

  logic       take_ns;
  logic       take_ew;
  logic       advance;
  logic [2:0] next_phase;

  // A button seen on the entry edge counts as already latched.
  assign take_ns = req_ns_q | bus.ped_req_ns;
  assign take_ew = req_ew_q | bus.ped_req_ew;
  assign advance = bus.tick && (timer_q <= 7'd1);

  // Fixed cyclic successor of each legal phase.
  always_comb begin
    next_phase = RED_A;
    case (phase_q)
      RED_A:     next_phase = NS_GREEN;
      NS_GREEN:  next_phase = NS_YELLOW;
      NS_YELLOW: next_phase = RED_B;
      RED_B:     next_phase = EW_GREEN;
      EW_GREEN:  next_phase = EW_YELLOW;
      EW_YELLOW: next_phase = RED_A;
      default:   next_phase = RED_A;
    endcase
  end

  // Phase, countdown, request latches and walk enables for the next edge.
  always_comb begin
    phase_d  = phase_q;
    timer_d  = timer_q;
    en_ns_d  = en_ns_q;
    en_ew_d  = en_ew_q;
    req_ns_d = req_ns_q | bus.ped_req_ns;
    req_ew_d = req_ew_q | bus.ped_req_ew;

    if (phase_q > EW_YELLOW) begin
      phase_d = RED_A;
      timer_d = T_ALL_RED;
      en_ns_d = 1'b0;
      en_ew_d = 1'b0;
    end else if (advance) begin
      phase_d = next_phase;
      en_ns_d = 1'b0;
      en_ew_d = 1'b0;
      case (next_phase)
        NS_GREEN: begin
          timer_d  = take_ns ? T_PED_GREEN : T_GREEN;
          en_ns_d  = take_ns;
          req_ns_d = 1'b0;
        end
        EW_GREEN: begin
          timer_d  = take_ew ? T_PED_GREEN : T_GREEN;
          en_ew_d  = take_ew;
          req_ew_d = 1'b0;
        end
        NS_YELLOW, EW_YELLOW: timer_d = T_YELLOW;
        default:              timer_d = T_ALL_RED;
      endcase
    end else if (bus.tick) begin
      timer_d = timer_q - 7'd1;
    end
  end

  // Lights follow the phase being entered so they change on the same edge.
  always_comb begin
    ns_light_d = LT_RED;
    ew_light_d = LT_RED;
    case (phase_d)
      NS_GREEN:  ns_light_d = LT_GREEN;
      NS_YELLOW: ns_light_d = LT_YELLOW;
      EW_GREEN:  ew_light_d = LT_GREEN;
      EW_YELLOW: ew_light_d = LT_YELLOW;
      default: begin
        ns_light_d = LT_RED;
        ew_light_d = LT_RED;
      end
    endcase
  end

  // State registers; reset wins over any phase activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= RED_A;
      timer_q    <= T_ALL_RED;
      ns_light_q <= LT_RED;
      ew_light_q <= LT_RED;
      en_ns_q    <= 1'b0;
      en_ew_q    <= 1'b0;
      req_ns_q   <= 1'b0;
      req_ew_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      en_ns_q    <= en_ns_d;
      en_ew_q    <= en_ew_d;
      req_ns_q   <= req_ns_d;
      req_ew_q   <= req_ew_d;
    end
  end

  assign bus.phase         = phase_q;
  assign bus.master_timer  = timer_q;
  assign bus.ns_light      = ns_light_q;
  assign bus.ew_light      = ew_light_q;
  assign bus.ped_enable_ns = en_ns_q;
  assign bus.ped_enable_ew = en_ew_q;

endmodule

// File: tb/tb_intersection_phase_controller.sv
// Directed bench for intersection_phase_controller: stimulus pushes the
// expected post-edge state into a queue, the monitor pops on each tick edge.
module tb_intersection_phase_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  intersection_phase_controller_if bus();

  intersection_phase_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] ph;
    logic [6:0] tmr;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       ens;
    logic       eew;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic force_chk = 1'b0;
  logic obs_q     = 1'b0;

  function automatic logic [2:0] ns_of(int ph);
    case (ph)
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(int ph);
    case (ph)
      4:       return 3'b001;
      5:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Marks the edges after which the DUT state is to be checked.
  always @(posedge clk) obs_q <= bus.tick | force_chk;

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    if (obs_q) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_sample phase=%0d timer=%0d (no expectation queued)",
                 bus.phase, bus.master_timer);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.phase === e.ph && bus.master_timer === e.tmr &&
            bus.ns_light === e.ns && bus.ew_light === e.ew &&
            bus.ped_enable_ns === e.ens && bus.ped_enable_ew === e.eew) begin
          n_pass++;
        end else begin
          $display("FAIL state t=%0t got ph=%0d tmr=%0d ns=%b ew=%b ens=%b eew=%b want ph=%0d tmr=%0d ns=%b ew=%b ens=%b eew=%b",
                   $time, bus.phase, bus.master_timer, bus.ns_light, bus.ew_light,
                   bus.ped_enable_ns, bus.ped_enable_ew,
                   e.ph, e.tmr, e.ns, e.ew, e.ens, e.eew);
        end
      end
    end
  end

  task automatic push(int ph, int tmr, bit ens, bit eew);
    exp_t e;
    e.ph  = 3'(ph);
    e.tmr = 7'(tmr);
    e.ns  = ns_of(ph);
    e.ew  = ew_of(ph);
    e.ens = ens;
    e.eew = eew;
    sb_q.push_back(e);
  endtask

  task automatic clk_idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(bit btn_ns, bit btn_ew);
    clk_idle(9);
    bus.tick       = 1'b1;
    bus.ped_req_ns = btn_ns;
    bus.ped_req_ew = btn_ew;
    @(posedge clk);
    #1;
    bus.tick       = 1'b0;
    bus.ped_req_ns = 1'b0;
    bus.ped_req_ew = 1'b0;
  endtask

  // One tick per expected timer value from 'from' down to 'to' in phase ph.
  task automatic ticks(int ph, int from, int to, bit ens, bit eew, bit ew_first = 1'b0);
    for (int k = from; k >= to; k--) begin
      push(ph, k, ens, eew);
      do_tick(1'b0, ew_first && (k == from));
    end
  endtask

  task automatic pulse_ns();
    bus.ped_req_ns = 1'b1;
    @(posedge clk);
    #1;
    bus.ped_req_ns = 1'b0;
  endtask

  task automatic check_now(int ph, int tmr, bit ens, bit eew);
    push(ph, tmr, ens, eew);
    force_chk = 1'b1;
    @(posedge clk);
    #1;
    force_chk = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    check_now(0, 2, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout expected_finish_by=2000000 reached_time=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.tick       = 1'b0;
    bus.ped_req_ns = 1'b0;
    bus.ped_req_ew = 1'b0;
    rst_n          = 1'b0;
    clk_idle(2);
    reset_pulse();

    // Plain cycle, no buttons: 2+30+4+2+30+4 ticks.
    ticks(0, 1, 1, 0, 0);
    ticks(1, 30, 1, 0, 0);
    ticks(2, 4, 1, 0, 0);
    ticks(3, 2, 1, 0, 0);
    ticks(4, 30, 1, 0, 0);
    ticks(5, 4, 1, 0, 0);
    ticks(0, 2, 1, 0, 0);

    // N-S button pulsed during RED_A; E-W button on the EW_GREEN entry edge.
    pulse_ns();
    ticks(1, 40, 1, 1, 0);
    ticks(2, 4, 1, 0, 0);
    ticks(3, 2, 1, 0, 0);
    ticks(4, 40, 1, 0, 1, 1'b1);
    ticks(5, 4, 1, 0, 0);
    ticks(0, 2, 1, 0, 0);

    // Request consumed: plain green; button at timer=15 waits for next green.
    ticks(1, 30, 15, 0, 0);
    pulse_ns();
    ticks(1, 14, 1, 0, 0);
    ticks(2, 4, 1, 0, 0);
    ticks(3, 2, 1, 0, 0);
    ticks(4, 30, 1, 0, 0);
    ticks(5, 4, 1, 0, 0);
    ticks(0, 2, 1, 0, 0);

    // Served walk green, frozen for 100 clk with tick low.
    ticks(1, 40, 20, 1, 0);
    repeat (10) begin
      clk_idle(9);
      check_now(1, 20, 1, 0);
    end
    ticks(1, 19, 1, 1, 0);
    ticks(2, 4, 1, 0, 0);
    ticks(3, 2, 1, 0, 0);

    // Reset during EW_GREEN with a pending N-S request.
    ticks(4, 30, 12, 0, 0);
    pulse_ns();
    reset_pulse();
    ticks(0, 1, 1, 0, 0);
    ticks(1, 30, 1, 0, 0);
    ticks(2, 4, 1, 0, 0);

    clk_idle(3);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intersection_phase_controller.md
Name: intersection_phase_controller

Overview:
- Sequences one two-road intersection: N-S and E-W vehicle lights, plus the 7-bit countdown and enables that feed the two pedestrian_light instances (one per crossing).
- Latches pedestrian push-button requests and grants a lengthened green with walk enabled to the requested crossing.
- Advances only on a one-cycle 1 Hz tick strobe from the top level.

Parameters:
- GREEN_TIME, 30, green duration in ticks with no pedestrian request (1..127).
- PED_GREEN_TIME, 40, green duration in ticks when a walk is granted (1..127).
- YELLOW_TIME, 4, yellow duration in ticks (1..127).
- ALL_RED_TIME, 2, all-red clearance duration in ticks (1..127).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- tick  input  1  one-cycle 1 Hz strobe; timer and phase advance only when high.
- ped_req_ns  input  1  N-S crosswalk button, level or pulse; sampled every clk.
- ped_req_ew  input  1  E-W crosswalk button.
- ns_light  output  3  {red,yellow,green}, one-hot.
- ew_light  output  3  {red,yellow,green}, one-hot.
- master_timer  output  7  ticks remaining in current phase; feeds pedestrian_light.master_timer.
- ped_enable_ns  output  1  enable for N-S pedestrian_light.
- ped_enable_ew  output  1  enable for E-W pedestrian_light.
- phase  output  3  current state code, for debug and bench.

Behaviour:
- Reset is synchronous, active-low, and takes priority over everything, including mid-phase.
  - On clk edge with rst_n=0: phase=RED_A, master_timer=ALL_RED_TIME.
  - ns_light=ew_light=3'b100, both ped_enables=0, both request latches cleared.
- States and codes, in cycle order:
  - RED_A(0) -> NS_GREEN(1) -> NS_YELLOW(2) -> RED_B(3) -> EW_GREEN(4) -> EW_YELLOW(5) -> RED_A.
  - Codes 6 and 7 are illegal; on the next edge they go to RED_A with master_timer=ALL_RED_TIME.
- Lights by state:
  - RED_A, RED_B: both 100.
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ew=001, ns=100.
  - EW_YELLOW: ew=010, ns=100.
  - Lights are registered and change on the same edge as the phase.
- Timer rule, per edge with tick=1:
  - If master_timer==1: advance to the next state and load its duration.
  - Otherwise: master_timer-1.
  - With tick=0, the timer holds.
  - Each phase lasts exactly its duration in ticks; master_timer never reads 0 and never wraps.
- Durations loaded:
  - Green: PED_GREEN_TIME if that direction's latch is set at entry, else GREEN_TIME.
  - Yellow: YELLOW_TIME.
  - Red: ALL_RED_TIME.
- Request latches (req_ns, req_ew):
  - Set on any clk with the button high.
  - req_ns is cleared on the edge entering NS_GREEN when it is consumed; req_ew likewise for EW_GREEN.
  - Button high on the same edge as entry: that request is consumed (served this green), and the latch ends cleared.
  - Button high during the served green or its yellow: latch sets and is served at that direction's next green.
- Walk grant:
  - ped_enable_ns=1 for the whole NS_GREEN phase if the latch was consumed at entry; 0 in all other states.
  - ped_enable_ew is symmetric.
  - The enable is registered with phase entry, so the first cycle of green already shows it.
- The walk crossing is parallel to the green road.
  - pedestrian_light derives walk/hand and digits from master_timer; this block does not compute them.

Test Plan:
- Reset, then tick every 10 clk, no buttons:
  - RED_A with timer 2,1.
  - NS_GREEN with timer 30..1, ns=001.
  - NS_YELLOW 4..1.
  - RED_B 2..1.
  - EW_GREEN 30..1.
  - EW_YELLOW 4..1.
  - Back to RED_A.
  - Full cycle = 72 ticks; ped_enables stay 0.
- Pulse ped_req_ns for 1 clk during RED_A:
  - NS_GREEN loads 40 with ped_enable_ns=1 for all 40 ticks.
  - Drops to 0 on entry to NS_YELLOW.
  - Next NS_GREEN loads 30.
- Assert ped_req_ew on the exact edge entering EW_GREEN:
  - That EW_GREEN loads 40, ped_enable_ew=1, and the latch is clear afterward.
- Pulse ped_req_ns mid NS_GREEN (timer=15):
  - Current green is unchanged at 30 with enable 0.
  - The following NS_GREEN loads 40 with enable 1.
- Hold tick=0 for 100 clk mid-phase:
  - master_timer, lights, and phase are frozen.
- Drop rst_n for 1 clk during EW_GREEN at timer=12 with a pending req_ns:
  - Next cycle: RED_A, timer=2, all red, enables 0.
  - Pending request discarded; the next NS_GREEN loads 30.
